// File: rtl/gauss_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gauss_pkg : kernel weights and arithmetic constants for the 3x3 blur        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package gauss_pkg;
  localparam int unsigned KERNEL_W [0:2][0:2] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
  localparam int KERNEL_SHIFT = 4;
  localparam int ROUND_BIAS   = 8;

  function automatic int sum_width(input int pbw);
    return pbw + 4;
  endfunction
endpackage
`default_nettype wire

// File: rtl/gaussian_filter_3x3_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_buffer : shift-enable delay line, dout = din from DEPTH enables ago    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module line_buffer #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (en) begin
      r_mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
    end
  end

  assign dout = r_mem[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/gaussian_filter_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gaussian_filter_3x3 : streaming valid-region 3x3 Gaussian blur, rounded     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gaussian_filter_3x3
  import gauss_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = 12,
  parameter int IMG_ROWS         = 20,
  parameter int IMG_COLS         = 20,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
  input  logic                       pixel_in_TVALID,
  output logic                       pixel_in_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
  output logic                       pixel_out_TVALID,
  input  logic                       pixel_out_TREADY,
  output logic                       pixel_out_TLAST
);
  localparam int c_SUM_W = sum_width(PIXEL_BIT_WIDTH);
  localparam logic [IMG_COL_BITWIDTH-1:0] c_LAST_COL = IMG_COL_BITWIDTH'(IMG_COLS - 1);
  localparam logic [IMG_ROW_BITWIDTH-1:0] c_LAST_ROW = IMG_ROW_BITWIDTH'(IMG_ROWS - 1);

  logic [IMG_COL_BITWIDTH-1:0] r_col;
  logic [IMG_ROW_BITWIDTH-1:0] r_row;
  logic [PIXEL_BIT_WIDTH-1:0]  r_win      [3][3];
  logic [PIXEL_BIT_WIDTH-1:0]  w_win_next [3][3];
  logic [PIXEL_BIT_WIDTH-1:0]  w_lb1_out, w_lb2_out, w_pix;
  logic [c_SUM_W-1:0]          w_sum, w_round;
  logic [PIXEL_BIT_WIDTH-1:0]  r_data;
  logic                        r_valid, r_last;
  logic                        w_acc, w_emit, w_col_end, w_row_end;

  assign pixel_in_TREADY = ~r_valid | pixel_out_TREADY;
  assign w_acc     = pixel_in_TVALID & pixel_in_TREADY;
  assign w_col_end = (r_col == c_LAST_COL);
  assign w_row_end = (r_row == c_LAST_ROW);
  assign w_emit    = w_acc && (r_row >= IMG_ROW_BITWIDTH'(2)) && (r_col >= IMG_COL_BITWIDTH'(2));

  // lb1 holds row r-1, lb2 (fed from lb1) holds row r-2
  line_buffer #(.WIDTH(PIXEL_BIT_WIDTH), .DEPTH(IMG_COLS)) u_lb1 (
    .clk(clk), .reset(reset), .en(w_acc), .din(pixel_in_TDATA), .dout(w_lb1_out)
  );
  line_buffer #(.WIDTH(PIXEL_BIT_WIDTH), .DEPTH(IMG_COLS)) u_lb2 (
    .clk(clk), .reset(reset), .en(w_acc), .din(w_lb1_out), .dout(w_lb2_out)
  );

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_win_next[i][0] = r_win[i][1];
      w_win_next[i][1] = r_win[i][2];
    end
    w_win_next[0][2] = w_lb2_out;
    w_win_next[1][2] = w_lb1_out;
    w_win_next[2][2] = pixel_in_TDATA;
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w_sum = w_sum + c_SUM_W'(KERNEL_W[i][j] * w_win_next[i][j]);
  end

  assign w_round = w_sum + c_SUM_W'(ROUND_BIAS);
  assign w_pix   = PIXEL_BIT_WIDTH'(w_round >> KERNEL_SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) r_win[i][j] <= '0;
    end else if (w_acc) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) r_win[i][j] <= w_win_next[i][j];
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_emit) begin
      r_data  <= w_pix;
      r_valid <= 1'b1;
      r_last  <= w_col_end & w_row_end;
    end else if (pixel_out_TREADY) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign pixel_out_TDATA  = r_data;
  assign pixel_out_TVALID = r_valid;
  assign pixel_out_TLAST  = r_last;
endmodule
`default_nettype wire

// File: tb/tb_gaussian_filter_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gaussian_filter_3x3 : bench for three filter sizes (4x4, 5x5, 3x3)       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_gaussian_filter_3x3;
  localparam int PBW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [PBW-1:0] din  [3];
  logic           vin  [3];
  logic           rdy  [3];
  logic [PBW-1:0] dout [3];
  logic           vout [3];
  logic           tr   [3];
  logic           lst  [3];

  int tests = 0;
  int fails = 0;
  int stim[$];
  int exp_d[$];
  int exp_l[$];
  int got_d[$];
  int got_l[$];

  gaussian_filter_3x3 #(.PIXEL_BIT_WIDTH(PBW), .IMG_ROWS(4), .IMG_COLS(4),
                        .IMG_ROW_BITWIDTH(10), .IMG_COL_BITWIDTH(10)) u_d4 (
    .clk(clk), .reset(rst_n),
    .pixel_in_TDATA(din[0]), .pixel_in_TVALID(vin[0]), .pixel_in_TREADY(rdy[0]),
    .pixel_out_TDATA(dout[0]), .pixel_out_TVALID(vout[0]), .pixel_out_TREADY(tr[0]),
    .pixel_out_TLAST(lst[0]));

  gaussian_filter_3x3 #(.PIXEL_BIT_WIDTH(PBW), .IMG_ROWS(5), .IMG_COLS(5),
                        .IMG_ROW_BITWIDTH(10), .IMG_COL_BITWIDTH(10)) u_d5 (
    .clk(clk), .reset(rst_n),
    .pixel_in_TDATA(din[1]), .pixel_in_TVALID(vin[1]), .pixel_in_TREADY(rdy[1]),
    .pixel_out_TDATA(dout[1]), .pixel_out_TVALID(vout[1]), .pixel_out_TREADY(tr[1]),
    .pixel_out_TLAST(lst[1]));

  gaussian_filter_3x3 #(.PIXEL_BIT_WIDTH(PBW), .IMG_ROWS(3), .IMG_COLS(3),
                        .IMG_ROW_BITWIDTH(10), .IMG_COL_BITWIDTH(10)) u_d3 (
    .clk(clk), .reset(rst_n),
    .pixel_in_TDATA(din[2]), .pixel_in_TVALID(vin[2]), .pixel_in_TREADY(rdy[2]),
    .pixel_out_TDATA(dout[2]), .pixel_out_TVALID(vout[2]), .pixel_out_TREADY(tr[2]),
    .pixel_out_TLAST(lst[2]));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Valid-region convolution of every complete R x C frame in stim
  function automatic void model(input int R, input int C);
    int n, nf, s, wt;
    n  = R * C;
    nf = stim.size() / n;
    exp_d.delete();
    exp_l.delete();
    for (int f = 0; f < nf; f++)
      for (int r = 1; r < R - 1; r++)
        for (int c = 1; c < C - 1; c++) begin
          s = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
              wt = ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
              s += wt * stim[f * n + (r + dr) * C + (c + dc)];
            end
          exp_d.push_back((s + 8) / 16);
          exp_l.push_back((r == R - 2 && c == C - 2) ? 1 : 0);
        end
  endfunction

  // vmode: 0 continuous TVALID, 1 random gaps. rmode: 0 TREADY=1, 1 pattern 1,0,0, 2 random
  task automatic run(input int d, input int vmode, input int rmode);
    int  idx = 0, cyc = 0, idle = 0;
    bit  stalled = 0;
    int  stall_data = 0;
    got_d.delete();
    got_l.delete();
    while ((idx < stim.size() || idle < 4) && cyc < 3000) begin
      @(negedge clk);
      case (rmode)
        0:       tr[d] = 1'b1;
        1:       tr[d] = ((cyc % 3) == 0);
        default: tr[d] = 1'($urandom_range(0, 1));
      endcase
      if (idx < stim.size()) begin
        vin[d] = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        din[d] = PBW'(stim[idx]);
      end else begin
        vin[d] = 1'b0;
        din[d] = PBW'($urandom);
      end
      #1;
      if (stalled) begin
        check("stall_valid", 32'(vout[d]), 32'd1);
        check("stall_data", 32'(dout[d]), stall_data);
      end
      if (vout[d] && !tr[d]) check("stall_in_ready", 32'(rdy[d]), 32'd0);
      stalled    = vout[d] && !tr[d];
      stall_data = int'(dout[d]);
      if (vout[d] && tr[d]) begin
        got_d.push_back(int'(dout[d]));
        got_l.push_back(int'(lst[d]));
      end
      if (vin[d] && rdy[d]) idx++;
      if (vout[d]) idle = 0;
      else if (idx >= stim.size()) idle++;
      cyc++;
    end
    check("run_timeout", 32'(cyc >= 3000), 32'd0);
    @(negedge clk);
    vin[d] = 1'b0;
    tr[d]  = 1'b1;
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, got_d.size(), exp_d.size());
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      check({tag, "_data"}, got_d[i], exp_d[i]);
      check({tag, "_last"}, got_l[i], exp_l[i]);
    end
  endtask

  task automatic fill_const(input int n, input int v);
    for (int i = 0; i < n; i++) stim.push_back(v);
  endtask

  initial begin
    int imp_exp [9] = '{10, 20, 10, 20, 40, 20, 10, 20, 10};
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      vin[d] = 1'b0; tr[d] = 1'b1; din[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_valid", 32'(vout[d]), 32'd0);
      check("reset_data", 32'(dout[d]), 32'd0);
      check("reset_last", 32'(lst[d]), 32'd0);
    end
    rst_n = 1'b1;

    // Constant 4x4 frame
    stim.delete(); fill_const(16, 100);
    model(4, 4); run(0, 0, 0); compare("const4");

    // Impulse on 5x5
    stim.delete(); fill_const(25, 0); stim[12] = 160;
    model(5, 5); run(1, 0, 0); compare("impulse5");
    check("impulse_count", got_d.size(), 9);
    for (int i = 0; i < 9 && i < got_d.size(); i++) check("impulse_value", got_d[i], imp_exp[i]);

    // Full scale 3x3
    stim.delete(); fill_const(9, 4095);
    model(3, 3); run(2, 0, 0); compare("full3");

    // Ramp with periodic backpressure
    stim.delete();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) stim.push_back(16 * r + c);
    model(4, 4); run(0, 0, 1); compare("ramp_bp");

    // Partial frame, then reset, then a clean frame
    stim.delete();
    for (int i = 0; i < 7; i++) stim.push_back(int'($urandom_range(0, 4095)));
    model(4, 4); run(0, 0, 0); compare("partial");
    @(negedge clk); rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      check("midreset_valid", 32'(vout[0]), 32'd0);
    end
    rst_n = 1'b1;
    stim.delete(); fill_const(16, 100);
    model(4, 4); run(0, 0, 0); compare("after_reset");

    // Back-to-back frames
    stim.delete(); fill_const(16, 100); fill_const(16, 200);
    model(4, 4); run(0, 0, 0); compare("b2b");

    // Random frames with random valid gaps and backpressure
    for (int k = 0; k < 3; k++) begin
      stim.delete();
      for (int i = 0; i < 32; i++) stim.push_back(int'($urandom_range(0, 4095)));
      model(4, 4); run(0, 1, 2); compare("rand4");
    end
    stim.delete();
    for (int i = 0; i < 50; i++) stim.push_back(int'($urandom_range(0, 4095)));
    model(5, 5); run(1, 1, 2); compare("rand5");
    stim.delete();
    for (int i = 0; i < 27; i++) stim.push_back(int'($urandom_range(0, 4095)));
    model(3, 3); run(2, 1, 2); compare("rand3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
